add_seq: RTL and testbench

Multi-precision add/subtract sequencer that drives one shared `add16` slice to compute `16*WORDS`-bit results over `WORDS` clock cycles. It processes one 16-bit word per cycle, least-significant first, and registers the inter-word carry. It sits between a requester using a valid/ready handshake and the existing 16-bit adder. It is the sequential front-end that lets wide arithmetic reuse the narrow combinational datapath.

---
 rtl/add_seq_if.sv | 29 ++
 rtl/add_seq.sv | 131 +++++++++++++
 tb/tb_add_seq.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/add_seq_if.sv
// Request/result bus for the multi-precision add/subtract sequencer.
// The master side is the requester and result consumer; the slave side is add_seq.
interface add_seq_if #(
    parameter int WORDS = 4
);
    localparam int W = 16 * WORDS;

    logic         in_valid;
    logic         in_ready;
    logic         in_sub;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout;
    logic         out_ovf;
    logic         out_zero;

    modport master (
        output in_valid, in_sub, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero
    );

    modport slave (
        input  in_valid, in_sub, in_a, in_b, out_ready,
        output in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero
    );
endinterface

// File: rtl/add_seq.sv
// Wide add/subtract built from one 16-bit adder slice, one word per cycle,
// least-significant word first, with the inter-word carry held in a flop.

module add16 (
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    input  logic        cin_i,
    output logic [15:0] sum_o,
    output logic        cout_o
);
    assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {16'b0, cin_i};
endmodule

// state  | meaning
// S_IDLE | in_ready high, waiting for a request
// S_RUN  | one word per cycle through add16, carry kept in carry_q
// S_DONE | out_valid high, result and flags held until out_ready
module add_seq #(
    parameter int WORDS = 4
) (
    input logic       clk,
    input logic       rst_n,
    add_seq_if.slave  bus
);
    localparam int CW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [WORDS-1:0][15:0] a_q, a_d;
    logic [WORDS-1:0][15:0] b_q, b_d;
    logic [WORDS-1:0][15:0] sum_q, sum_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   carry_q, carry_d;
    logic                   cout_q, cout_d;
    logic                   ovf_q, ovf_d;
    logic                   zero_q, zero_d;

    logic [15:0] add_s;
    logic        add_c;

    add16 u_add16 (
        .a_i    (a_q[cnt_q]),
        .b_i    (b_q[cnt_q]),
        .cin_i  (carry_q),
        .sum_o  (add_s),
        .cout_o (add_c)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;

        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    // Subtraction is a + ~b + 1: invert B once and seed the carry.
                    a_d     = bus.in_a;
                    b_d     = bus.in_sub ? ~bus.in_b : bus.in_b;
                    carry_d = bus.in_sub;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                sum_d[cnt_q] = add_s;
                carry_d      = add_c;
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    cout_d  = add_c;
                    ovf_d   = (a_q[WORDS-1][15] == b_q[WORDS-1][15]) &&
                              (add_s[15] != a_q[WORDS-1][15]);
                    zero_d  = ~|sum_d;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.out_sum   = sum_q;
    assign bus.out_cout  = cout_q;
    assign bus.out_ovf   = ovf_q;
    assign bus.out_zero  = zero_q;
endmodule

// File: tb/tb_add_seq.sv
// Self-checking bench for add_seq (WORDS=4): directed corner cases, random
// operations against a plain 64-bit arithmetic model, backpressure and reset.
module tb_add_seq;
    localparam int WORDS = 4;
    localparam int W     = 16 * WORDS;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    add_seq_if #(.WORDS(WORDS)) bus ();

    add_seq #(.WORDS(WORDS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
        logic [W-1:0] s;
        logic         c;
        logic         o;
        logic         z;
    } vec_t;

    // Reference: plain wide arithmetic and signed-overflow rules.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic sub, output logic [W-1:0] s,
                                  output logic c, output logic o, output logic z);
        logic [W:0] full;
        if (sub) begin
            s = a - b;
            c = (a >= b);
            o = (a[W-1] != b[W-1]) && (s[W-1] != a[W-1]);
        end else begin
            full = {1'b0, a} + {1'b0, b};
            s = full[W-1:0];
            c = full[W];
            o = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
        end
        z = (s == '0);
    endfunction

    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_sub   = sub;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_a     = {$urandom(), $urandom()};
        bus.in_b     = {$urandom(), $urandom()};
        bus.in_sub   = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 20) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic pop_result;
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_sub    = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus.in_ready, bus.out_valid, bus.out_cout, bus.out_ovf, bus.out_zero} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_ctrl got rdy/vld/c/o/z=%b expected 10000",
                     {bus.in_ready, bus.out_valid, bus.out_cout, bus.out_ovf, bus.out_zero});
        end
        checks++;
        if (bus.out_sum !== '0) begin
            errors++;
            $display("FAIL reset_sum got %h expected 0", bus.out_sum);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_directed;
        vec_t v[6];
        int   lat;
        v[0] = '{64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 64'h0000_0000_0001_0000, 1'b0, 1'b0, 1'b0};
        v[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0,                   1'b1, 1'b0, 1'b1};
        v[2] = '{64'h5,                   64'h7, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0};
        v[3] = '{64'h7,                   64'h5, 1'b1, 64'h2,                   1'b1, 1'b0, 1'b0};
        v[4] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0};
        v[5] = '{64'h8000_0000_0000_0000, 64'h1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 6; i++) begin
            bus.out_ready = 1'b0;
            start_op(v[i].a, v[i].b, v[i].sub);
            wait_done(lat);
            checks++;
            if (lat !== WORDS) begin
                errors++;
                $display("FAIL dir%0d_latency got %0d expected %0d", i, lat, WORDS);
            end
            checks++;
            if (bus.out_sum !== v[i].s) begin
                errors++;
                $display("FAIL dir%0d_sum got %h expected %h", i, bus.out_sum, v[i].s);
            end
            checks++;
            if ({bus.out_cout, bus.out_ovf, bus.out_zero} !== {v[i].c, v[i].o, v[i].z}) begin
                errors++;
                $display("FAIL dir%0d_flags got c/o/z=%b expected %b", i,
                         {bus.out_cout, bus.out_ovf, bus.out_zero}, {v[i].c, v[i].o, v[i].z});
            end
            pop_result();
            checks++;
            if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
                errors++;
                $display("FAIL dir%0d_release got rdy/vld=%b expected 10", i,
                         {bus.in_ready, bus.out_valid});
            end
        end
    endtask

    task automatic test_random;
        logic [W-1:0] a, b, es;
        logic         sub, ec, eo, ez;
        int           lat;
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0: begin a = {$urandom(), $urandom()}; b = {$urandom(), $urandom()}; end
                1: begin a = {$urandom(), 32'hFFFF_FFFF}; b = 64'h1; end
                2: begin a = {$urandom(), $urandom()}; b = a; end
                default: begin a = 64'($urandom_range(0, 255)); b = 64'($urandom_range(0, 255)); end
            endcase
            sub = 1'($urandom_range(0, 1));
            model(a, b, sub, es, ec, eo, ez);
            start_op(a, b, sub);
            wait_done(lat);
            checks++;
            if (lat !== WORDS) begin
                errors++;
                $display("FAIL rnd%0d_latency got %0d expected %0d", i, lat, WORDS);
            end
            checks++;
            if (bus.out_sum !== es) begin
                errors++;
                $display("FAIL rnd%0d_sum a=%h b=%h sub=%b got %h expected %h",
                         i, a, b, sub, bus.out_sum, es);
            end
            checks++;
            if ({bus.out_cout, bus.out_ovf, bus.out_zero} !== {ec, eo, ez}) begin
                errors++;
                $display("FAIL rnd%0d_flags a=%h b=%h sub=%b got c/o/z=%b expected %b",
                         i, a, b, sub, {bus.out_cout, bus.out_ovf, bus.out_zero}, {ec, eo, ez});
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
            pop_result();
        end
    endtask

    task automatic test_backpressure;
        logic [W-1:0] a, b, es;
        logic         sub, ec, eo, ez;
        int           lat;
        a   = {$urandom(), $urandom()};
        b   = {$urandom(), $urandom()};
        sub = 1'b1;
        model(a, b, sub, es, ec, eo, ez);
        start_op(a, b, sub);
        wait_done(lat);
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.in_a     = {$urandom(), $urandom()};
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_sum !== es ||
                {bus.out_cout, bus.out_ovf, bus.out_zero} !== {ec, eo, ez}) begin
                errors++;
                $display("FAIL bp_hold%0d got vld=%b rdy=%b sum=%h coz=%b expected 1 0 %h %b",
                         i, bus.out_valid, bus.in_ready, bus.out_sum,
                         {bus.out_cout, bus.out_ovf, bus.out_zero}, es, {ec, eo, ez});
            end
        end
        // Request offered in the same cycle as the output handshake must not be taken.
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        checks++;
        if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
            errors++;
            $display("FAIL bp_release got rdy/vld=%b expected 10", {bus.in_ready, bus.out_valid});
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
            errors++;
            $display("FAIL bp_no_accept got rdy/vld=%b expected 10", {bus.in_ready, bus.out_valid});
        end
    endtask

    task automatic test_reset_mid_run;
        int lat;
        start_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if ({bus.in_ready, bus.out_valid, bus.out_cout, bus.out_ovf, bus.out_zero} !== 5'b10000) begin
            errors++;
            $display("FAIL midrst_ctrl got rdy/vld/c/o/z=%b expected 10000",
                     {bus.in_ready, bus.out_valid, bus.out_cout, bus.out_ovf, bus.out_zero});
        end
        checks++;
        if (bus.out_sum !== '0) begin
            errors++;
            $display("FAIL midrst_sum got %h expected 0", bus.out_sum);
        end
        start_op(64'h1234, 64'h1, 1'b0);
        wait_done(lat);
        checks++;
        if (lat !== WORDS) begin
            errors++;
            $display("FAIL midrst_latency got %0d expected %0d", lat, WORDS);
        end
        checks++;
        if (bus.out_sum !== 64'h1235 || {bus.out_cout, bus.out_ovf, bus.out_zero} !== 3'b000) begin
            errors++;
            $display("FAIL midrst_result got sum=%h c/o/z=%b expected 1235 000",
                     bus.out_sum, {bus.out_cout, bus.out_ovf, bus.out_zero});
        end
        pop_result();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
